// File: rtl/coherent_mem_arbiter.sv
// Shared RAM port arbiter for CPUS instruction/data cache pairs with a snoop
// phase for coherent data misses and cache-to-cache forwarding of dirty lines.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | pick next requester: data round-robin first, then instruction
// SNOOP  | broadcast snoop address/invalidate to all cores except g
// FWD    | dirty line from responder r goes to g and is written back
// RAMD   | plain data access to RAM for core g
// RAMI   | instruction fetch from RAM for core g
module coherent_mem_arbiter #(
  parameter int CPUS      = 4,
  parameter int WORD_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int SNOOP_LAT = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [CPUS-1:0]          iREN,
  input  logic [CPUS*ADDR_W-1:0]   iaddr,
  input  logic [CPUS-1:0]          dREN,
  input  logic [CPUS-1:0]          dWEN,
  input  logic [CPUS*ADDR_W-1:0]   daddr,
  input  logic [CPUS*WORD_W-1:0]   dstore,
  input  logic [CPUS-1:0]          cctrans,
  input  logic [CPUS-1:0]          ccwrite,
  output logic [CPUS-1:0]          iwait,
  output logic [CPUS-1:0]          dwait,
  output logic [CPUS*WORD_W-1:0]   iload,
  output logic [CPUS*WORD_W-1:0]   dload,
  output logic [CPUS-1:0]          ccwait,
  output logic [CPUS-1:0]          ccinv,
  output logic [CPUS*ADDR_W-1:0]   ccsnoopaddr,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [ADDR_W-1:0]        ramaddr,
  output logic [WORD_W-1:0]        ramstore,
  input  logic [WORD_W-1:0]        ramload,
  input  logic [1:0]               ramstate
);

  localparam int         GW         = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [3:0] SCNT_LAST  = 4'(SNOOP_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNOOP,
    S_FWD,
    S_RAMD,
    S_RAMI
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   g_q, g_d;
  logic [GW-1:0]   r_q, r_d;
  logic [GW-1:0]   dptr_q, dptr_d;
  logic [GW-1:0]   iptr_q, iptr_d;
  logic [3:0]      scnt_q, scnt_d;

  logic [ADDR_W-1:0] iaddr_a  [CPUS];
  logic [ADDR_W-1:0] daddr_a  [CPUS];
  logic [WORD_W-1:0] dstore_a [CPUS];

  for (genvar k = 0; k < CPUS; k++) begin : g_unpack
    assign iaddr_a[k]  = iaddr[k*ADDR_W +: ADDR_W];
    assign daddr_a[k]  = daddr[k*ADDR_W +: ADDR_W];
    assign dstore_a[k] = dstore[k*WORD_W +: WORD_W];
  end

  logic [CPUS-1:0] dreq;
  logic            ram_acc;
  logic            resp_vld;
  logic [GW-1:0]   resp_idx;

  assign dreq    = dREN | dWEN;
  assign ram_acc = (ramstate == RAM_ACCESS);

  // Nearest requester above ptr wins, so iterate far-to-near and let the last hit stand.
  function automatic logic [GW-1:0] rr_pick(input logic [CPUS-1:0] req,
                                            input logic [GW-1:0]   ptr);
    logic [GW-1:0] pick;
    pick = ptr;
    for (int k = CPUS; k >= 1; k--) begin
      int idx;
      idx = (int'(ptr) + k) % CPUS;
      if (req[idx]) pick = GW'(idx);
    end
    return pick;
  endfunction

  // Lowest-numbered snooper (other than the requester) holding a dirty line.
  always_comb begin
    resp_vld = 1'b0;
    resp_idx = '0;
    for (int j = CPUS - 1; j >= 0; j--) begin
      if (dWEN[j] && (GW'(j) != g_q)) begin
        resp_vld = 1'b1;
        resp_idx = GW'(j);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      r_q     <= '0;
      dptr_q  <= GW'(CPUS - 1);
      iptr_q  <= GW'(CPUS - 1);
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      r_q     <= r_d;
      dptr_q  <= dptr_d;
      iptr_q  <= iptr_d;
      scnt_q  <= scnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    r_d         = r_q;
    dptr_d      = dptr_q;
    iptr_d      = iptr_q;
    scnt_d      = scnt_q;
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    unique case (state_q)
      S_IDLE: begin
        scnt_d = '0;
        if (|dreq) begin
          g_d     = rr_pick(dreq, dptr_q);
          dptr_d  = g_d;
          state_d = cctrans[g_d] ? S_SNOOP : S_RAMD;
        end else if (|iREN) begin
          g_d     = rr_pick(iREN, iptr_q);
          iptr_d  = g_d;
          state_d = S_RAMI;
        end
      end

      S_SNOOP: begin
        for (int j = 0; j < CPUS; j++) begin
          if (GW'(j) != g_q) begin
            ccwait[j]                         = 1'b1;
            ccinv[j]                          = ccwrite[g_q];
            ccsnoopaddr[j*ADDR_W +: ADDR_W]   = daddr_a[g_q];
          end
        end
        if (!dreq[g_q]) begin
          scnt_d  = '0;
          state_d = S_IDLE;
        end else if (scnt_q == SCNT_LAST) begin
          scnt_d  = '0;
          if (resp_vld) begin
            r_d     = resp_idx;
            state_d = S_FWD;
          end else begin
            state_d = S_RAMD;
          end
        end else begin
          scnt_d = scnt_q + 4'd1;
        end
      end

      S_FWD: begin
        ccwait[r_q] = 1'b1;
        ramWEN      = 1'b1;
        ramaddr     = daddr_a[r_q];
        ramstore    = dstore_a[r_q];
        for (int k = 0; k < CPUS; k++) begin
          if (GW'(k) == g_q) dload[k*WORD_W +: WORD_W] = dstore_a[r_q];
        end
        if (ram_acc) begin
          dwait[r_q] = 1'b0;
          dwait[g_q] = 1'b0;
          state_d    = S_IDLE;
        end
      end

      S_RAMD: begin
        ramREN   = dREN[g_q];
        ramWEN   = dWEN[g_q] & ~dREN[g_q];
        ramaddr  = daddr_a[g_q];
        ramstore = dstore_a[g_q];
        for (int k = 0; k < CPUS; k++) begin
          if (GW'(k) == g_q) dload[k*WORD_W +: WORD_W] = ramload;
        end
        if (!dreq[g_q]) begin
          state_d = S_IDLE;
        end else if (ram_acc) begin
          dwait[g_q] = 1'b0;
          state_d    = S_IDLE;
        end
      end

      S_RAMI: begin
        ramREN  = 1'b1;
        ramaddr = iaddr_a[g_q];
        for (int k = 0; k < CPUS; k++) begin
          if (GW'(k) == g_q) iload[k*WORD_W +: WORD_W] = ramload;
        end
        if (!iREN[g_q]) begin
          state_d = S_IDLE;
        end else if (ram_acc) begin
          iwait[g_q] = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_coherent_mem_arbiter.sv
// Directed bench for coherent_mem_arbiter: arbitration order, snoop/forward,
// RAM stalls, reset abort and request drop, all with hand-computed expectations.
module tb_coherent_mem_arbiter;

  localparam int CPUS = 4;
  localparam int WW   = 32;
  localparam int AW   = 32;
  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic                  CLK, RST;
  logic [CPUS-1:0]       iREN, dREN, dWEN, cctrans, ccwrite;
  logic [CPUS*AW-1:0]    iaddr, daddr;
  logic [CPUS*WW-1:0]    dstore;
  logic [CPUS-1:0]       iwait, dwait, ccwait, ccinv;
  logic [CPUS*WW-1:0]    iload, dload;
  logic [CPUS*AW-1:0]    ccsnoopaddr;
  logic                  ramREN, ramWEN;
  logic [AW-1:0]         ramaddr;
  logic [WW-1:0]         ramstore, ramload;
  logic [1:0]            ramstate;

  int n_checks = 0;
  int n_errors = 0;

  coherent_mem_arbiter #(
    .CPUS(CPUS), .WORD_W(WW), .ADDR_W(AW), .SNOOP_LAT(1)
  ) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .cctrans(cctrans), .ccwrite(ccwrite),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
  endtask

  function automatic logic [WW-1:0] dload_of(input int k);
    return dload[k*WW +: WW];
  endfunction

  function automatic logic [WW-1:0] iload_of(input int k);
    return iload[k*WW +: WW];
  endfunction

  function automatic logic [AW-1:0] snoop_of(input int k);
    return ccsnoopaddr[k*AW +: AW];
  endfunction

  initial begin
    RST = 1'b0;
    clear_inputs();
    #1 RST = 1'b1;
    #2;
    check_eq("rst dwait",  dwait,  4'hF);
    check_eq("rst iwait",  iwait,  4'hF);
    check_eq("rst ramREN", ramREN, 1'b0);
    check_eq("rst ramWEN", ramWEN, 1'b0);
    check_eq("rst ccwait", ccwait, 4'h0);
    @(posedge CLK);
    #1 RST = 1'b0;

    // two reads in one cycle, then round-robin continues from core 2
    step();
    daddr[0*AW +: AW] = 32'h10; daddr[1*AW +: AW] = 32'h30;
    daddr[2*AW +: AW] = 32'h20; daddr[3*AW +: AW] = 32'h40;
    ramload = 32'h1111; ramstate = ACCESS; dREN = 4'b0101;
    @(negedge CLK);
    check_eq("rd idle dwait", dwait, 4'hF);
    check_eq("rd idle ren", ramREN, 1'b0);
    step(); @(negedge CLK);
    check_eq("rd0 ren", ramREN, 1'b1);
    check_eq("rd0 addr", ramaddr, 32'h10);
    check_eq("rd0 dwait", dwait, 4'b1110);
    check_eq("rd0 dload", dload_of(0), 32'h1111);
    step(); dREN = 4'b0100; @(negedge CLK);
    check_eq("rd2 idle ren", ramREN, 1'b0);
    step(); @(negedge CLK);
    check_eq("rd2 addr", ramaddr, 32'h20);
    check_eq("rd2 dwait", dwait, 4'b1011);
    step(); dREN = 4'b1010; @(negedge CLK);
    step(); @(negedge CLK);
    check_eq("rr3 addr", ramaddr, 32'h40);
    check_eq("rr3 dwait", dwait, 4'b0111);
    step(); dREN = 4'b0010; @(negedge CLK);
    step(); @(negedge CLK);
    check_eq("rr1 addr", ramaddr, 32'h30);
    check_eq("rr1 dwait", dwait, 4'b1101);
    step(); clear_inputs();

    // coherent read, no dirty responder
    step();
    dREN = 4'b0010; cctrans = 4'b0010; daddr[1*AW +: AW] = 32'h100;
    ramload = 32'hCAFE; ramstate = ACCESS;
    @(negedge CLK);
    step(); @(negedge CLK);
    check_eq("snp ccwait", ccwait, 4'b1101);
    check_eq("snp addr0", snoop_of(0), 32'h100);
    check_eq("snp addr3", snoop_of(3), 32'h100);
    check_eq("snp addr1", snoop_of(1), 32'h0);
    check_eq("snp ccinv", ccinv, 4'b0000);
    check_eq("snp strobes", {ramREN, ramWEN}, 2'b00);
    check_eq("snp dwait", dwait, 4'hF);
    step(); @(negedge CLK);
    check_eq("cr ren", ramREN, 1'b1);
    check_eq("cr addr", ramaddr, 32'h100);
    check_eq("cr dload", dload_of(1), 32'hCAFE);
    check_eq("cr dwait", dwait, 4'b1101);
    check_eq("cr ccwait", ccwait, 4'b0000);
    step(); clear_inputs();

    // BusRdX from core 0, core 3 supplies dirty line
    step();
    dREN = 4'b0001; cctrans = 4'b0001; ccwrite = 4'b0001;
    daddr[0*AW +: AW] = 32'h200; ramstate = ACCESS;
    @(negedge CLK);
    step();
    dWEN = 4'b1000; daddr[3*AW +: AW] = 32'h200; dstore[3*WW +: WW] = 32'hBEEF;
    @(negedge CLK);
    check_eq("fwd ccinv", ccinv, 4'b1110);
    check_eq("fwd snp ccwait", ccwait, 4'b1110);
    step(); @(negedge CLK);
    check_eq("fwd wen", ramWEN, 1'b1);
    check_eq("fwd ren", ramREN, 1'b0);
    check_eq("fwd addr", ramaddr, 32'h200);
    check_eq("fwd store", ramstore, 32'hBEEF);
    check_eq("fwd dload", dload_of(0), 32'hBEEF);
    check_eq("fwd dwait", dwait, 4'b0110);
    check_eq("fwd ccwait", ccwait, 4'b1000);
    step(); clear_inputs();

    // RAM stall: BUSY x5, ERROR x2, then ACCESS
    step();
    dWEN = 4'b0100; daddr[2*AW +: AW] = 32'h300; dstore[2*WW +: WW] = 32'h55;
    ramstate = BUSY;
    @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      step(); @(negedge CLK);
      check_eq("stall busy dwait", dwait, 4'hF);
    end
    check_eq("stall wen", ramWEN, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step(); ramstate = ERROR; @(negedge CLK);
      check_eq("stall err dwait", dwait, 4'hF);
    end
    step(); ramstate = ACCESS; @(negedge CLK);
    check_eq("stall acc dwait", dwait, 4'b1011);
    check_eq("stall acc strobes", {ramREN, ramWEN}, 2'b01);
    check_eq("stall acc store", ramstore, 32'h55);
    check_eq("stall acc addr", ramaddr, 32'h300);
    step(); clear_inputs();

    // reset asserted mid-FWD
    step();
    dREN = 4'b0010; cctrans = 4'b0010; ccwrite = 4'b0010;
    daddr[1*AW +: AW] = 32'h400; ramstate = BUSY;
    @(negedge CLK);
    step();
    dWEN = 4'b0001; daddr[0*AW +: AW] = 32'h400; dstore[0*WW +: WW] = 32'h77;
    @(negedge CLK);
    check_eq("abort snp ccwait", ccwait, 4'b1101);
    step(); @(negedge CLK);
    check_eq("abort fwd wen", ramWEN, 1'b1);
    check_eq("abort fwd store", ramstore, 32'h77);
    check_eq("abort fwd dwait", dwait, 4'hF);
    #2 RST = 1'b1;
    #1;
    check_eq("abort wen", ramWEN, 1'b0);
    check_eq("abort ren", ramREN, 1'b0);
    check_eq("abort dwait", dwait, 4'hF);
    check_eq("abort ccwait", ccwait, 4'h0);
    check_eq("abort dload", dload, '0);
    check_eq("abort addr", ramaddr, 32'h0);
    @(posedge CLK);
    #1 RST = 1'b0;
    clear_inputs();

    // continuous iREN on all cores; data preempts only at IDLE
    step();
    iREN = 4'b1111; ramload = 32'h1234; ramstate = ACCESS;
    for (int k = 0; k < CPUS; k++) iaddr[k*AW +: AW] = 32'h1000 + 32'(4 * k);
    @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      int k;
      logic [3:0] exp_iw;
      k = i % 4;
      exp_iw = ~(4'b0001 << k);
      step();
      if (i == 4) begin
        dREN = 4'b0010; daddr[1*AW +: AW] = 32'h500;
      end
      @(negedge CLK);
      check_eq("istv addr", ramaddr, 32'h1000 + 32'(4 * k));
      check_eq("istv iwait", iwait, exp_iw);
      check_eq("istv iload", iload_of(k), 32'h1234);
      step(); @(negedge CLK);
      check_eq("istv idle ren", ramREN, 1'b0);
    end
    step(); @(negedge CLK);
    check_eq("preempt dwait", dwait, 4'b1101);
    check_eq("preempt iwait", iwait, 4'hF);
    check_eq("preempt addr", ramaddr, 32'h500);
    step(); dREN = 4'b0000; @(negedge CLK);
    step(); @(negedge CLK);
    check_eq("resume addr", ramaddr, 32'h1004);
    check_eq("resume iwait", iwait, 4'b1101);
    step(); clear_inputs();

    // request dropped in RAMD
    step();
    dREN = 4'b0100; daddr[2*AW +: AW] = 32'h600; ramstate = BUSY;
    @(negedge CLK);
    step(); @(negedge CLK);
    check_eq("drop ren", ramREN, 1'b1);
    step(); dREN = 4'b0000; ramstate = ACCESS; @(negedge CLK);
    check_eq("drop dwait", dwait, 4'hF);
    check_eq("drop ren off", ramREN, 1'b0);
    step(); iREN = 4'b0010; iaddr[1*AW +: AW] = 32'h700; @(negedge CLK);
    check_eq("drop idle ren", ramREN, 1'b0);
    step(); @(negedge CLK);
    check_eq("drop next addr", ramaddr, 32'h700);
    check_eq("drop next iwait", iwait, 4'b1101);
    step(); clear_inputs();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/coherent_mem_arbiter.md
# coherent_mem_arbiter

Parametrised successor to the two-CPU memory controller. It arbitrates one shared RAM port among CPUS instruction and data caches, using round-robin fairness for both the data and the instruction request classes. It runs a snoop phase for coherent data misses, broadcasting the snoop address and an invalidate to every other cache. A dirty line supplied by a snooper is forwarded cache-to-cache and written back to RAM in the same transaction. It sits between the per-core caches and the RAM model in the multicore top level.

## Interface
- CPUS, 4: number of cores; 2..8.
- WORD_W, 32: data word width.
- ADDR_W, 32: byte address width.
- SNOOP_LAT, 1: cycles the snoop broadcast is held before responses are sampled; 1..15.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- iREN  in  CPUS  instruction read request, one bit per core.
- iaddr  in  CPUS*ADDR_W  instruction address; core k occupies slice k.
- dREN, dWEN  in  CPUS each  data read and data write requests.
- daddr, dstore  in  CPUS*ADDR_W, CPUS*WORD_W  data address and write data.
- cctrans, ccwrite  in  CPUS each  coherent miss flag; ccwrite marks a miss-for-write (BusRdX).
- iwait, dwait  out  CPUS each  high means stall; a low pulse completes the request.
- iload, dload  out  CPUS*WORD_W each  returned instruction and data words.
- ccwait, ccinv  out  CPUS each  snoop-hold flag and invalidate flag to a snooped cache.
- ccsnoopaddr  out  CPUS*ADDR_W  address being snooped.
- ramREN, ramWEN  out  1 each  RAM read and write strobes.
- ramaddr, ramstore  out  ADDR_W, WORD_W  RAM address and RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  RAM status from cpu_types_pkg: FREE, BUSY, ACCESS, ERROR.

## Operation
- Registered state: FSM state, g (granted core), r (snoop responder), dptr and iptr (round-robin pointers), snoop counter scnt.
- Round-robin rule: the grant is the first requesting core after the pointer, searching upward with wrap. On each grant the pointer is set to the granted core.
- Data requests (dREN|dWEN) always take priority over instruction requests.
- IDLE state:
  - Any data request: grant g from dptr. Go to SNOOP if cctrans[g] is set, otherwise go to RAMD.
  - Otherwise, any iREN: grant g from iptr and go to RAMI.
  - Otherwise stay in IDLE.
- SNOOP state:
  - For every j≠g drive ccwait[j]=1, ccsnoopaddr[j]=daddr[g], ccinv[j]=ccwrite[g].
  - scnt counts from 0 to SNOOP_LAT-1.
  - On the last count: if any j≠g has dWEN[j] set, latch the lowest such j as r and go to FWD; otherwise go to RAMD.
- FWD state:
  - Keep ccwait[r]=1.
  - Drive ramWEN=1, ramaddr=daddr[r], ramstore=dstore[r], dload[g]=dstore[r].
  - On ACCESS: drive dwait[r]=0 and dwait[g]=0, then go to IDLE.
- RAMD state:
  - Drive ramREN=dREN[g], ramWEN=dWEN[g] & ~dREN[g], ramaddr=daddr[g], ramstore=dstore[g], dload[g]=ramload.
  - On ACCESS: drive dwait[g]=0, then go to IDLE.
- RAMI state:
  - Drive ramREN=1, ramaddr=iaddr[g], iload[g]=ramload.
  - On ACCESS: drive iwait[g]=0, then go to IDLE.
- Request dropped: if the granted request drops in SNOOP, RAMD or RAMI, go to IDLE next cycle. No wait is released.
- ERROR and FREE are treated as BUSY: no wait is released and the state holds.
- Default output values: all iwait and dwait are 1, all other outputs are 0.

## Timing
- Reset values: state IDLE, dptr=iptr=CPUS-1 (so core 0 has first priority), scnt=0, all iwait and dwait 1, all other outputs 0.
- Reset applied mid-transaction aborts immediately, including any RAM strobes.
- All outputs are combinational from the registered state and the inputs. dwait and iwait fall in the same cycle that ramstate==ACCESS.
- Minimum latency: uncoherent access 1 cycle in IDLE plus 1 access cycle. Coherent access adds SNOOP_LAT cycles; FWD replaces RAMD.
- Exactly one wait line per class is released per transaction; in FWD, two dwait lines are released together.
- Only one RAM strobe is asserted in any cycle, and none is asserted in IDLE or SNOOP.
- When several cores request in the same cycle, the round-robin rule decides. A starved core waits at most CPUS-1 grants of its class.

## Test plan
- Two reads in one cycle: after reset, dREN[0]=dREN[2]=1 with ramstate ACCESS immediately. Core 0 completes at cycle 2 and core 2 at cycle 4; dptr ends at 2.
- Coherent read snoop: core1 asserts cctrans=1, ccwrite=0, daddr=0x100. In SNOOP, ccwait and ccsnoopaddr=0x100 go to cores 0, 2 and 3, with ccinv all 0. No snooper sets dWEN, so RAMD reads 0x100 and returns ramload 0xCAFE to dload[1].
- Dirty-line forward: core0 asserts BusRdX (ccwrite=1) to 0x200, and core3 answers with dWEN and dstore=0xBEEF. Then ccinv[3]=1, FWD writes 0xBEEF to RAM at 0x200, dload[0]=0xBEEF, and dwait[0] and dwait[3] fall together.
- Instruction starvation: continuous iREN on all four cores. Grant order is 0,1,2,3,0, and data requests preempt instruction grants only at IDLE.
- RAM stall and error: hold ramstate BUSY for 5 cycles, then ERROR for 2, then ACCESS. dwait is released only on the ACCESS cycle.
- Reset and abort: assert RST mid-FWD and confirm all outputs return to reset values asynchronously. Separately, drop dREN in RAMD and confirm IDLE next cycle with no dwait low.
